// File: rtl/clock_source_manager_pkg.sv
// ---------------------------------------------------------------------------
// clock_source_manager_pkg
//   Shared types for the clock source manager: the switchover FSM state
//   encoding and the switchover target encoding.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

package clock_source_manager_pkg;

    // Switchover sequencer states
    typedef enum logic [2:0] {
        IDLE,
        RUN_PRIORITY,
        RUN_FALLBACK,
        GAP_OFF,
        GAP_ON
    } state_e;

    // Where a switchover sequence is heading once the enable gap has elapsed
    typedef enum logic [1:0] {
        NONE,
        PRIORITY,
        FALLBACK
    } target_e;

endpackage

// File: rtl/clock_activity_detector.sv
// ---------------------------------------------------------------------------
// clock_activity_detector
//   Qualifies one clock source as alive or dead from its divide-by-2
//   heartbeat toggle. The heartbeat is synchronized, every edge is counted
//   per measurement window, and a window is good when the count lies in
//   [MIN_EDGES, MAX_EDGES]. GOOD_WINDOWS consecutive good windows raise
//   alive; any bad window drops it.
//
// Ports:
//   clock         in   reference clock
//   resetn        in   asynchronous active-low reset
//   heartbeat_i   in   asynchronous heartbeat toggle
//   window_end_i  in   one-cycle strobe on the last cycle of each window
//   alive_o       out  registered qualified status, changes only on window ends
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module clock_activity_detector #(
    parameter int STAGES       = 2,
    parameter int MIN_EDGES    = 4,
    parameter int MAX_EDGES    = 32,
    parameter int GOOD_WINDOWS = 2
) (
    input  logic clock,
    input  logic resetn,
    input  logic heartbeat_i,
    input  logic window_end_i,
    output logic alive_o
);

    localparam int EdgeW = $clog2(MAX_EDGES + 2);
    localparam int GoodW = $clog2(GOOD_WINDOWS + 1);

    localparam logic [EdgeW-1:0] EdgeSat    = EdgeW'(MAX_EDGES + 1);
    localparam logic [EdgeW-1:0] EdgeMin    = EdgeW'(MIN_EDGES);
    localparam logic [EdgeW-1:0] EdgeMax    = EdgeW'(MAX_EDGES);
    localparam logic [GoodW-1:0] GoodTarget = GoodW'(GOOD_WINDOWS);

    logic [STAGES-1:0] sync_q;
    logic              prevSync_q;
    logic              edgeSeen;
    logic              windowGood;
    logic [EdgeW-1:0]  edgeCount_q, edgeCount_d;
    logic [GoodW-1:0]  goodCount_q, goodCount_d;
    logic              alive_q, alive_d;

    // Synchronizer chain plus one extra flop holding the previous
    // synchronized value so both heartbeat edges can be detected.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync_q     <= '0;
            prevSync_q <= 1'b0;
        end else begin
            sync_q     <= {sync_q[STAGES-2:0], heartbeat_i};
            prevSync_q <= sync_q[STAGES-1];
        end
    end

    assign edgeSeen   = sync_q[STAGES-1] ^ prevSync_q;
    assign windowGood = (edgeCount_q >= EdgeMin) && (edgeCount_q <= EdgeMax);

    // Window-end evaluation. An edge arriving on the wrap cycle belongs to
    // the next window, so the counter restarts at 1 in that case. The edge
    // counter saturates one past MAX_EDGES so "too fast" stays detectable.
    always_comb begin
        edgeCount_d = edgeCount_q;
        goodCount_d = goodCount_q;
        alive_d     = alive_q;
        if (window_end_i) begin
            edgeCount_d = edgeSeen ? EdgeW'(1) : '0;
            if (windowGood) begin
                goodCount_d = (goodCount_q == GoodTarget) ? goodCount_q
                                                          : goodCount_q + GoodW'(1);
                alive_d     = (goodCount_d == GoodTarget);
            end else begin
                goodCount_d = '0;
                alive_d     = 1'b0;
            end
        end else if (edgeSeen && (edgeCount_q != EdgeSat)) begin
            edgeCount_d = edgeCount_q + EdgeW'(1);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            edgeCount_q <= '0;
            goodCount_q <= '0;
            alive_q     <= 1'b0;
        end else begin
            edgeCount_q <= edgeCount_d;
            goodCount_q <= goodCount_d;
            alive_q     <= alive_d;
        end
    end

    assign alive_o = alive_q;

endmodule

// File: rtl/clock_source_manager.sv
// ---------------------------------------------------------------------------
// clock_source_manager
//   Control block for the clock fallback mux. Owns the shared measurement
//   window counter, two activity detectors (priority and fallback source)
//   and the break-before-make switchover FSM driving the mux select and the
//   output clock gate enable.
//
// Optional feature (macro CLOCK_SOURCE_MANAGER_FAULT_COUNTER_EN):
//   adds fault_clear input and fault_count[7:0] output, a saturating count
//   of alive 1->0 transitions of either source.
//
// Ports:
//   clock               in   reference clock, always running
//   resetn              in   asynchronous active-low reset
//   priority_heartbeat  in   async divide-by-2 toggle of the priority clock
//   fallback_heartbeat  in   async divide-by-2 toggle of the fallback clock
//   fault_clear         in   (optional) synchronous counter clear
//   fault_count         out  (optional) saturating fault count
//   select_fallback     out  mux select, 0 = priority, 1 = fallback
//   output_enable       out  clock gate enable for the mux output
//   priority_alive      out  qualified status of the priority source
//   fallback_alive      out  qualified status of the fallback source
//   switching           out  high while a switchover sequence runs
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module clock_source_manager
    import clock_source_manager_pkg::*;
#(
    parameter int STAGES        = 2,
    parameter int WINDOW_CYCLES = 64,
    parameter int MIN_EDGES     = 4,
    parameter int MAX_EDGES     = 32,
    parameter int GOOD_WINDOWS  = 2,
    parameter int SWITCH_GAP    = 8
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       priority_heartbeat,
    input  logic       fallback_heartbeat,
`ifdef CLOCK_SOURCE_MANAGER_FAULT_COUNTER_EN
    input  logic       fault_clear,
    output logic [7:0] fault_count,
`endif
    output logic       select_fallback,
    output logic       output_enable,
    output logic       priority_alive,
    output logic       fallback_alive,
    output logic       switching
);

    localparam int WinW = $clog2(WINDOW_CYCLES + 1);
    localparam int GapW = $clog2(SWITCH_GAP + 1);

    localparam logic [WinW-1:0] WinLast = WinW'(WINDOW_CYCLES - 1);
    localparam logic [GapW-1:0] GapLast = GapW'(SWITCH_GAP - 1);

    logic [WinW-1:0] windowCount_q, windowCount_d;
    logic            windowEnd;
    logic            priorityAlive;
    logic            fallbackAlive;

    state_e          state_q;
    target_e         target_q;
    logic [GapW-1:0] gapCount_q;
    logic            select_q;
    logic            enable_q;
    logic            switching_q;

    // Shared window counter; both detectors evaluate on the same strobe.
    assign windowEnd     = (windowCount_q == WinLast);
    assign windowCount_d = windowEnd ? '0 : windowCount_q + WinW'(1);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            windowCount_q <= '0;
        end else begin
            windowCount_q <= windowCount_d;
        end
    end

    clock_activity_detector #(
        .STAGES       (STAGES),
        .MIN_EDGES    (MIN_EDGES),
        .MAX_EDGES    (MAX_EDGES),
        .GOOD_WINDOWS (GOOD_WINDOWS)
    ) u_priority_detector (
        .clock        (clock),
        .resetn       (resetn),
        .heartbeat_i  (priority_heartbeat),
        .window_end_i (windowEnd),
        .alive_o      (priorityAlive)
    );

    clock_activity_detector #(
        .STAGES       (STAGES),
        .MIN_EDGES    (MIN_EDGES),
        .MAX_EDGES    (MAX_EDGES),
        .GOOD_WINDOWS (GOOD_WINDOWS)
    ) u_fallback_detector (
        .clock        (clock),
        .resetn       (resetn),
        .heartbeat_i  (fallback_heartbeat),
        .window_end_i (windowEnd),
        .alive_o      (fallbackAlive)
    );

    // Switchover sequencer. The enable is dropped on entry to GAP_OFF and
    // select only moves on the GAP_OFF->GAP_ON transition (or from IDLE,
    // where the enable is already low), so select never changes while the
    // gate is open or in the cycle it closes. Each gap phase lasts
    // SWITCH_GAP cycles. Status changes seen during GAP_OFF are deliberately
    // not acted on; the following RUN state re-evaluates them.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            target_q    <= NONE;
            gapCount_q  <= '0;
            select_q    <= 1'b0;
            enable_q    <= 1'b0;
            switching_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    enable_q <= 1'b0;
                    if (priorityAlive) begin
                        select_q    <= 1'b0;
                        gapCount_q  <= '0;
                        switching_q <= 1'b1;
                        state_q     <= GAP_ON;
                    end else if (fallbackAlive) begin
                        select_q    <= 1'b1;
                        gapCount_q  <= '0;
                        switching_q <= 1'b1;
                        state_q     <= GAP_ON;
                    end
                end
                RUN_PRIORITY: begin
                    if (!priorityAlive) begin
                        enable_q    <= 1'b0;
                        gapCount_q  <= '0;
                        switching_q <= 1'b1;
                        target_q    <= fallbackAlive ? FALLBACK : NONE;
                        state_q     <= GAP_OFF;
                    end
                end
                RUN_FALLBACK: begin
                    // The priority source always wins when it comes back.
                    if (priorityAlive) begin
                        enable_q    <= 1'b0;
                        gapCount_q  <= '0;
                        switching_q <= 1'b1;
                        target_q    <= PRIORITY;
                        state_q     <= GAP_OFF;
                    end else if (!fallbackAlive) begin
                        enable_q    <= 1'b0;
                        gapCount_q  <= '0;
                        switching_q <= 1'b1;
                        target_q    <= NONE;
                        state_q     <= GAP_OFF;
                    end
                end
                GAP_OFF: begin
                    if (gapCount_q == GapLast) begin
                        gapCount_q <= '0;
                        if (target_q == NONE) begin
                            switching_q <= 1'b0;
                            state_q     <= IDLE;
                        end else begin
                            select_q <= (target_q == FALLBACK);
                            state_q  <= GAP_ON;
                        end
                    end else begin
                        gapCount_q <= gapCount_q + GapW'(1);
                    end
                end
                GAP_ON: begin
                    if (select_q ? !fallbackAlive : !priorityAlive) begin
                        gapCount_q  <= '0;
                        switching_q <= 1'b0;
                        state_q     <= IDLE;
                    end else if (gapCount_q == GapLast) begin
                        gapCount_q  <= '0;
                        enable_q    <= 1'b1;
                        switching_q <= 1'b0;
                        state_q     <= select_q ? RUN_FALLBACK : RUN_PRIORITY;
                    end else begin
                        gapCount_q <= gapCount_q + GapW'(1);
                    end
                end
                default: begin
                    enable_q    <= 1'b0;
                    switching_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign select_fallback = select_q;
    assign output_enable   = enable_q;
    assign switching       = switching_q;
    assign priority_alive  = priorityAlive;
    assign fallback_alive  = fallbackAlive;

`ifdef CLOCK_SOURCE_MANAGER_FAULT_COUNTER_EN
    logic       priorityAlivePrev_q;
    logic       fallbackAlivePrev_q;
    logic       priorityDrop;
    logic       fallbackDrop;
    logic [8:0] faultSum;
    logic [7:0] faultCount_q, faultCount_d;

    assign priorityDrop = priorityAlivePrev_q & ~priorityAlive;
    assign fallbackDrop = fallbackAlivePrev_q & ~fallbackAlive;

    // Both sources may drop on the same window end, so add both flags in a
    // 9-bit sum and clamp. Clear has priority over any increment.
    always_comb begin
        faultSum     = {1'b0, faultCount_q} + {8'b0, priorityDrop} + {8'b0, fallbackDrop};
        faultCount_d = faultSum[8] ? 8'hFF : faultSum[7:0];
        if (fault_clear) begin
            faultCount_d = '0;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            priorityAlivePrev_q <= 1'b0;
            fallbackAlivePrev_q <= 1'b0;
            faultCount_q        <= '0;
        end else begin
            priorityAlivePrev_q <= priorityAlive;
            fallbackAlivePrev_q <= fallbackAlive;
            faultCount_q        <= faultCount_d;
        end
    end

    assign fault_count = faultCount_q;
`endif

endmodule

// File: tb/tb_clock_source_manager.sv
// ---------------------------------------------------------------------------
// tb_clock_source_manager
//   Directed bench for clock_source_manager. Heartbeats are generated by a
//   background process whose toggle periods the main sequence sets. The bench
//   counts reference-clock rising edges since reset release; window m ends on
//   rising edge 64*m, so alive changes are visible at the following falling
//   edge, where all sampling happens.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_clock_source_manager;

    logic       clock;
    logic       resetn;
    logic       priorityHeartbeat;
    logic       fallbackHeartbeat;
    logic       selectFallback;
    logic       outputEnable;
    logic       priorityAlive;
    logic       fallbackAlive;
    logic       switching;
`ifdef CLOCK_SOURCE_MANAGER_FAULT_COUNTER_EN
    logic       faultClear;
    logic [7:0] faultCount;
`endif

    int assertCount = 0;
    int failCount   = 0;
    int posCount;
    int priorityPeriod = 0;
    int fallbackPeriod = 0;

    clock_source_manager dut (
        .clock              (clock),
        .resetn             (resetn),
        .priority_heartbeat (priorityHeartbeat),
        .fallback_heartbeat (fallbackHeartbeat),
`ifdef CLOCK_SOURCE_MANAGER_FAULT_COUNTER_EN
        .fault_clear        (faultClear),
        .fault_count        (faultCount),
`endif
        .select_fallback    (selectFallback),
        .output_enable      (outputEnable),
        .priority_alive     (priorityAlive),
        .fallback_alive     (fallbackAlive),
        .switching          (switching)
    );

    // 100 MHz reference clock
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Rising edges since reset release; drives the window arithmetic
    always @(posedge clock or negedge resetn) begin
        if (!resetn) posCount <= 0;
        else         posCount <= posCount + 1;
    end

    // Heartbeat generator: toggles each source every N falling edges,
    // holding its level when the period is 0.
    initial begin
        int pCnt;
        int fCnt;
        pCnt = 0;
        fCnt = 0;
        priorityHeartbeat = 1'b0;
        fallbackHeartbeat = 1'b0;
        forever begin
            @(negedge clock);
            if (priorityPeriod != 0) begin
                pCnt = pCnt + 1;
                if (pCnt >= priorityPeriod) begin
                    priorityHeartbeat = ~priorityHeartbeat;
                    pCnt = 0;
                end
            end else begin
                pCnt = 0;
            end
            if (fallbackPeriod != 0) begin
                fCnt = fCnt + 1;
                if (fCnt >= fallbackPeriod) begin
                    fallbackHeartbeat = ~fallbackHeartbeat;
                    fCnt = 0;
                end
            end else begin
                fCnt = 0;
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input int pPeriod, input int fPeriod);
        priorityPeriod = pPeriod;
        fallbackPeriod = fPeriod;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        assertCount = assertCount + 1;
        assert (observed === expected)
        else begin
            failCount = failCount + 1;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Packs {sel, en, sw, pAlive, fAlive} into one comparison
    task automatic checkState(input string tag, input logic sel, input logic en,
                              input logic sw, input logic pa, input logic fa);
        checkOutput(tag,
                    {3'b000, selectFallback, outputEnable, switching, priorityAlive, fallbackAlive},
                    {3'b000, sel, en, sw, pa, fa});
    endtask

    task automatic waitCycle(input int n);
        while (posCount < n) @(negedge clock);
    endtask

    // Called at the falling edge where a status change becomes visible while
    // running; expects 16 cycles of enable low with select moving only
    // halfway through, then the enable back high on the new source.
    task automatic checkGap(input string tag, input logic oldSel, input logic newSel);
        for (int i = 0; i < 16; i++) begin
            @(negedge clock);
            checkOutput({tag, "_gap"},
                        {5'b00000, outputEnable, switching, selectFallback},
                        {5'b00000, 1'b0, 1'b1, (i < 8) ? oldSel : newSel});
        end
        @(negedge clock);
        checkOutput({tag, "_done"},
                    {5'b00000, outputEnable, switching, selectFallback},
                    {5'b00000, 1'b1, 1'b0, newSel});
    endtask

    initial begin
        resetn = 1'b0;
`ifdef CLOCK_SOURCE_MANAGER_FAULT_COUNTER_EN
        faultClear = 1'b0;
`endif
        applyStimulus(0, 0);
        repeat (3) @(negedge clock);
        checkState("reset_state", 0, 0, 0, 0, 0);
        resetn = 1'b1;

        // 1: no heartbeats for 10 windows
        for (int m = 1; m <= 10; m++) begin
            waitCycle(64 * m);
            checkState("idle_window", 0, 0, 0, 0, 0);
        end
        $display("[TB] scenario 1 done");

        // 2: both sources start; priority wins when both qualify together
        applyStimulus(4, 3);
        waitCycle(767);
        checkState("pre_alive", 0, 0, 0, 0, 0);
        waitCycle(768);
        checkState("both_alive", 0, 0, 0, 1, 1);
        waitCycle(769);
        checkState("gap_on_start", 0, 0, 1, 1, 1);
        waitCycle(776);
        checkState("gap_on_end", 0, 0, 1, 1, 1);
        waitCycle(777);
        checkState("run_priority", 0, 1, 0, 1, 1);
        $display("[TB] scenario 2 done");

        // 3: priority stops, switch to fallback
        waitCycle(800);
        applyStimulus(0, 3);
        waitCycle(895);
        checkState("prio_still_alive", 0, 1, 0, 1, 1);
        waitCycle(896);
        checkState("prio_dead", 0, 1, 0, 0, 1);
        checkGap("to_fallback", 1'b0, 1'b1);
`ifdef CLOCK_SOURCE_MANAGER_FAULT_COUNTER_EN
        checkOutput("fault_after_s3", faultCount, 8'd1);
`endif
        $display("[TB] scenario 3 done");

        // 4: priority revives, gated switch back
        waitCycle(960);
        applyStimulus(4, 3);
        waitCycle(1087);
        checkState("prio_one_good", 1, 1, 0, 0, 1);
        waitCycle(1088);
        checkState("prio_revived", 1, 1, 0, 1, 1);
        checkGap("to_priority", 1'b1, 1'b0);
        $display("[TB] scenario 4 done");

        // 5: priority toggling every cycle is too fast
        waitCycle(1152);
        applyStimulus(1, 3);
        waitCycle(1215);
        checkState("fast_pre", 0, 1, 0, 1, 1);
        waitCycle(1216);
        checkState("fast_dead", 0, 1, 0, 0, 1);
        checkGap("fast_to_fallback", 1'b0, 1'b1);
        for (int m = 20; m <= 22; m++) begin
            waitCycle(64 * m);
            checkState("fast_stays_dead", 1, 1, 0, 0, 1);
        end
        $display("[TB] scenario 5 done");

        // 6: fallback dies too, reset during GAP_OFF
        applyStimulus(1, 0);
`ifdef CLOCK_SOURCE_MANAGER_FAULT_COUNTER_EN
        checkOutput("fault_before_clear", faultCount, 8'd2);
        faultClear = 1'b1;
        @(negedge clock);
        faultClear = 1'b0;
        checkOutput("fault_cleared", faultCount, 8'd0);
`endif
        waitCycle(1471);
        checkState("fb_still_alive", 1, 1, 0, 0, 1);
        waitCycle(1472);
        checkState("fb_dead", 1, 1, 0, 0, 0);
        waitCycle(1473);
        checkState("gap_off_none", 1, 0, 1, 0, 0);
`ifdef CLOCK_SOURCE_MANAGER_FAULT_COUNTER_EN
        checkOutput("fault_fb_drop", faultCount, 8'd1);
`endif
        waitCycle(1476);
        resetn = 1'b0;
        #2;
        checkState("async_reset", 0, 0, 0, 0, 0);
`ifdef CLOCK_SOURCE_MANAGER_FAULT_COUNTER_EN
        checkOutput("fault_reset", faultCount, 8'd0);
`endif
        @(negedge clock);
        resetn = 1'b1;
        repeat (5) @(negedge clock);
        checkState("post_reset", 0, 0, 0, 0, 0);
        $display("[TB] scenario 6 done");

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/clock_source_manager.md
Name: clock_source_manager

Overview:
- Control block for the clock fallback mux. Runs on an always-on reference clock and monitors the priority and fallback clock sources through divide-by-2 heartbeat toggles.
- Qualifies each source as alive or dead using per-window edge counting with hysteresis.
- Sequences the mux select with a gated, break-before-make switchover.
- Sits beside the clock fallback cell and drives its select and enable inputs.

Parameters:
STAGES, 2, synchronizer depth for each heartbeat input (≥2)
WINDOW_CYCLES, 64, reference-clock cycles per measurement window
MIN_EDGES, 4, minimum heartbeat edges per window for a good window
MAX_EDGES, 32, maximum heartbeat edges per window for a good window (above = too fast/noisy)
GOOD_WINDOWS, 2, consecutive good windows before a source is declared alive
SWITCH_GAP, 8, reference cycles output_enable stays low around a select change

Ports:
clock  input  1  reference clock, always running
resetn  input  1  asynchronous active-low reset
priority_heartbeat  input  1  asynchronous toggle, divide-by-2 of priority clock
fallback_heartbeat  input  1  asynchronous toggle, divide-by-2 of fallback clock
select_fallback  output  1  mux select: 0 = priority, 1 = fallback
output_enable  output  1  clock gate enable for the mux output
priority_alive  output  1  qualified status of priority source
fallback_alive  output  1  qualified status of fallback source
switching  output  1  high while a switchover sequence is in progress

Behaviour:
- Reset: all outputs 0. Window counter, edge counters, hysteresis counters and synchronizers all 0. FSM in IDLE.
- Heartbeat path:
  - STAGES-flop synchronizer, then XOR edge detect against the previous synchronized value.
  - Either edge counts as one edge. The edge counter saturates at MAX_EDGES+1.
- Window timing:
  - The window counter counts 0..WINDOW_CYCLES-1 and wraps.
  - On the wrap cycle, the window is good if MIN_EDGES ≤ count ≤ MAX_EDGES.
  - The edge counter restarts at 0, or at 1 if an edge lands on the wrap cycle itself.
  - Counter widths are $clog2(WINDOW_CYCLES+1) and $clog2(MAX_EDGES+2).
- Alive qualification:
  - A bad window clears alive immediately and resets the good-window count.
  - A good window increments the count, saturating at GOOD_WINDOWS.
  - alive goes high on the window end where the count reaches GOOD_WINDOWS.
  - alive updates only on window ends. Dead-detection latency is ≤2 windows plus STAGES cycles.
- FSM states: IDLE, RUN_PRIORITY, RUN_FALLBACK, GAP_OFF, GAP_ON.
- IDLE:
  - output_enable=0.
  - If priority_alive: select=0, go to GAP_ON.
  - Else if fallback_alive: select=1, go to GAP_ON.
- RUN_PRIORITY:
  - output_enable=1, select=0.
  - If !priority_alive: go to GAP_OFF with target fallback if fallback_alive, else target none.
- RUN_FALLBACK:
  - output_enable=1, select=1.
  - If priority_alive: go to GAP_OFF with target priority (the priority source always wins).
  - Else if !fallback_alive: go to GAP_OFF with target none.
- GAP_OFF:
  - output_enable=0 for SWITCH_GAP cycles.
  - Then: target none → IDLE; otherwise update select and go to GAP_ON.
- GAP_ON:
  - output_enable=0 for SWITCH_GAP cycles, select stable.
  - Then enter the matching RUN state.
  - If the selected source's alive drops during GAP_ON, go to IDLE.
- Status changes during GAP_OFF are ignored; they are re-evaluated in the next RUN state.
- Invariant: select_fallback never changes while output_enable=1, nor in the cycle output_enable falls.
- switching = (state is GAP_OFF or GAP_ON).
- If both alive statuses change on the same window end, priority takes precedence.
- Reset asserted mid-switch: asynchronous return to all-zero outputs.

Optional Feature:
- Macro: CLOCK_SOURCE_MANAGER_FAULT_COUNTER_EN.
- Defined:
  - Adds output fault_count [7:0].
  - Increments, saturating at 255, on every alive 1→0 transition of either source.
  - Simultaneous drops add 2 (still saturating).
  - Adds input fault_clear, synchronous to clock; it zeroes the counter and wins over a same-cycle increment.
- Undefined: neither port exists and no counter logic is built.

Decomposition:
- Package clock_source_manager_pkg holds:
  - the state enum;
  - the source target enum (NONE, PRIORITY, FALLBACK).
- Sub-module clock_activity_detector contains:
  - synchronizer, edge detect, edge counter and window-end evaluation;
  - the hysteresis counter and the alive output.
- It takes the shared window-end strobe as an input and is instantiated twice. The top level owns the window counter and the FSM.

Test Plan:
1. Both heartbeats idle after reset → all outputs stay 0 for 10 windows.
2. Priority heartbeat toggles every 4 cycles (16 edges/window) →
   - priority_alive=1 at the end of window 2;
   - output_enable=1 after 8 cycles in GAP_ON;
   - select_fallback=0.
3. Both running, then priority stops →
   - priority_alive=0 within 2 windows;
   - output_enable low for 16 cycles;
   - select_fallback changes to 1 only while output_enable=0, and is 1 when output_enable returns high.
4. Priority revives while on fallback → after 2 good windows, gated switch back to select_fallback=0; the enable gap is exactly 16 cycles.
5. Priority toggles every cycle (64 edges > MAX_EDGES) → priority_alive stays 0 and fallback remains selected.
6. resetn pulsed low during GAP_OFF → outputs are 0 asynchronously. With CLOCK_SOURCE_MANAGER_FAULT_COUNTER_EN defined: fault_count=1 after scenario 3 and 0 after fault_clear.
